// File: rtl/ram_sweep_ctrl.sv
// Read-modify-write increment of one RAM word, then a full address sweep streamed downstream.
// The RAM read port is registered, so streamed data follows each sweep read by one cycle.
module ram_sweep_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 4,
   parameter int unsigned DATA_WIDTH  = 2,
   parameter int unsigned TARGET_ADDR = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  r_en,
   output logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [DATA_WIDTH-1:0] r_data,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] Target   = ADDR_WIDTH'(TARGET_ADDR);
   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

   typedef enum logic [2:0] {
      StIdle, StRdReq, StRdWait, StWrite, StSweep, StDrain, StDone
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rmw_q, rmw_d;
   logic                  w_en_q, w_en_d, r_en_q, r_en_d;
   logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d, r_addr_q, r_addr_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                  out_valid_q, out_valid_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic                  busy_q, busy_d, done_q, done_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rmw_d   = rmw_q;
      unique case (state_q)
         StIdle:   if (go) state_d = StRdReq;
         StRdReq:  state_d = StRdWait;
         StRdWait: begin
            rmw_d   = r_data;
            state_d = StWrite;
         end
         StWrite: begin
            cnt_d   = '0;
            state_d = StSweep;
         end
         StSweep: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LastAddr) state_d = StDrain;
         end
         StDrain:  state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Strobes are decoded from the next state so they register in step with state_q.
   always_comb begin
      w_en_d      = (state_d == StWrite);
      w_addr_d    = w_en_d ? Target : '0;
      w_data_d    = w_en_d ? rmw_d + DATA_WIDTH'(1) : '0;
      r_en_d      = (state_d == StRdReq) || (state_d == StSweep);
      r_addr_d    = (state_d == StRdReq) ? Target :
                    (state_d == StSweep) ? cnt_d  : '0;
      out_valid_d = (state_q == StSweep);
      out_addr_d  = out_valid_d ? cnt_q : '0;
      busy_d      = (state_d != StIdle);
      done_d      = (state_d == StDone);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rmw_q       <= '0;
         w_en_q      <= 1'b0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         r_en_q      <= 1'b0;
         r_addr_q    <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rmw_q       <= rmw_d;
         w_en_q      <= w_en_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         r_en_q      <= r_en_d;
         r_addr_q    <= r_addr_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign w_en      = w_en_q;
   assign w_addr    = w_addr_q;
   assign w_data    = w_data_q;
   assign r_en      = r_en_q;
   assign r_addr    = r_addr_q;
   assign out_valid = out_valid_q;
   assign out_addr  = out_addr_q;
   // r_data is already a RAM register output; only gated here so it reads 0 when not valid.
   assign out_data  = out_valid_q ? r_data : '0;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Directed bench for ram_sweep_ctrl with a 16x2 registered-read RAM model.
// A negedge monitor checks every write and streamed beat against a small reference model.
module tb_ram_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       go  = 1'b0;
   logic       w_en, r_en, out_valid, busy, done;
   logic [3:0] w_addr, r_addr, out_addr;
   logic [1:0] w_data, r_data, out_data;

   ram_sweep_ctrl #(
      .ADDR_WIDTH (4),
      .DATA_WIDTH (2),
      .TARGET_ADDR(12)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .r_en     (r_en),
      .r_addr   (r_addr),
      .r_data   (r_data),
      .out_valid(out_valid),
      .out_addr (out_addr),
      .out_data (out_data),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Preload pattern: addr 12 holds 1.
   function automatic logic [1:0] init_val(input int a);
      return 2'((3 * a + 1) & 3);
   endfunction

   logic [1:0] mem [16];
   logic       reinit = 1'b1;

   always @(posedge clk) begin
      if (reinit) begin
         for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
         r_data <= 2'd0;
      end else begin
         if (w_en) mem[w_addr] <= w_data;
         if (r_en) r_data <= mem[r_addr];
      end
   end

   int exp12 = 1, last12 = -1;
   int n_wr = 0, n_beat = 0, n_done = 0, beat_idx = 0, overlap = 0, hyg = 0;

   function automatic int exp_word(input int a);
      return (a == 12) ? exp12 : int'(init_val(a));
   endfunction

   always @(negedge clk) begin
      if (w_en && r_en) overlap++;
      if ((!w_en && (w_addr != 0 || w_data != 0)) || (!r_en && r_addr != 0) ||
          (!out_valid && (out_addr != 0 || out_data != 0))) hyg++;
      if (rst) begin
         beat_idx = 0;
      end else begin
         if (w_en) begin
            n_wr++;
            exp12 = (exp12 + 1) & 3;
            check("wr_addr", 32'(w_addr), 12);
            check("wr_data", 32'(w_data), 32'(exp12));
         end
         if (out_valid) begin
            check("beat_addr", 32'(out_addr), 32'(beat_idx));
            check("beat_data", 32'(out_data), 32'(exp_word(int'(out_addr))));
            if (out_addr == 4'd12) last12 = int'(out_data);
            beat_idx++;
            n_beat++;
         end
         if (done) begin
            n_done++;
            check("done_beats", 32'(beat_idx), 16);
            beat_idx = 0;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic go_pulse();
      go = 1'b1;
      tick();
      go = 1'b0;
   endtask

   task automatic check_deltas(input string tag, input int wr0, input int bt0, input int dn0,
                               input int wr, input int bt, input int dn);
      check({tag, "_writes"}, 32'(n_wr - wr0), 32'(wr));
      check({tag, "_beats"}, 32'(n_beat - bt0), 32'(bt));
      check({tag, "_dones"}, 32'(n_done - dn0), 32'(dn));
   endtask

   int wr0, bt0, dn0, nz, cyc, first_v, done_cyc, idle_cnt;
   int wrap_exp [4];

   initial begin
      // Test 1: reset and idle quiet
      tick(); tick();
      reinit = 1'b0;
      rst = 1'b0;
      check("rst_busy", 32'(busy), 0);
      check("rst_strobes", 32'({w_en, r_en, out_valid, done}), 0);
      nz = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if ({w_en, r_en, out_valid, busy, done, w_addr, w_data, r_addr, out_addr, out_data} != 0)
            nz++;
      end
      check("idle_quiet", 32'(nz), 0);

      // Test 2: single go with latency checks
      wr0 = n_wr; bt0 = n_beat; dn0 = n_done;
      first_v = -1; done_cyc = -1; cyc = 0;
      go = 1'b1;
      while (done_cyc < 0 && cyc < 40) begin
         tick();
         go = 1'b0;
         cyc++;
         if (cyc == 1) begin
            check("rdreq_busy", 32'(busy), 1);
            check("rdreq_raddr", 32'({r_en, r_addr}), 32'({1'b1, 4'd12}));
         end
         if (cyc == 3) check("write_cycle", 32'(w_en), 1);
         if (out_valid && first_v < 0) first_v = cyc;
         if (done) done_cyc = cyc;
      end
      check("first_valid_lat", 32'(first_v), 5);
      check("done_lat", 32'(done_cyc), 21);
      tick();
      check("idle_after_done", 32'(busy), 0);
      check_deltas("single", wr0, bt0, dn0, 1, 16, 1);
      check("single_addr12", 32'(last12), 2);

      // Test 3: wrap-around from a fresh preload
      reinit = 1'b1; tick(); reinit = 1'b0; exp12 = 1;
      wrap_exp[0] = 2; wrap_exp[1] = 3; wrap_exp[2] = 0; wrap_exp[3] = 1;
      for (int p = 0; p < 4; p++) begin
         go_pulse();
         for (int i = 0; i < 39; i++) tick();
         check("wrap_addr12", 32'(last12), 32'(wrap_exp[p]));
      end

      // Test 4: go while busy is ignored
      wr0 = n_wr; bt0 = n_beat; dn0 = n_done;
      go_pulse();
      for (int i = 0; i < 4; i++) tick();
      go_pulse();
      for (int i = 0; i < 40; i++) tick();
      check_deltas("busy_go", wr0, bt0, dn0, 1, 16, 1);

      // Test 5: reset at the 8th streamed beat
      dn0 = n_done;
      go_pulse();
      cyc = 0;
      while (beat_idx < 8 && cyc < 40) begin
         tick();
         cyc++;
      end
      check("reach_beat8", 32'(beat_idx), 8);
      rst = 1'b1;
      tick();
      check("rst_mid_strobes", 32'({out_valid, r_en, w_en, busy, done}), 0);
      for (int i = 0; i < 4; i++) tick();
      rst = 1'b0;
      tick();
      check("rst_no_done", 32'(n_done - dn0), 0);
      wr0 = n_wr; bt0 = n_beat; dn0 = n_done;
      go_pulse();
      for (int i = 0; i < 30; i++) tick();
      check_deltas("post_rst", wr0, bt0, dn0, 1, 16, 1);

      // Test 6: go held high for 60 cycles
      wr0 = n_wr; bt0 = n_beat; dn0 = n_done;
      idle_cnt = 0;
      go = 1'b1;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (!busy) idle_cnt++;
      end
      go = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check("held_idle_gaps", 32'(idle_cnt), 2);
      check_deltas("held", wr0, bt0, dn0, 3, 48, 3);

      check("we_re_overlap", 32'(overlap), 0);
      check("strobe_hygiene", 32'(hyg), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ram_sweep_ctrl.md
Name: ram_sweep_ctrl

Overview:
- Sequencer that sits directly upstream of the 16x2 block RAM tester and drives its write and read ports.
- On a single-cycle `go` pulse it performs a read-modify-write increment of one target word.
- It then sweeps every address and streams the read data, with address and valid strobe, to downstream display/LED logic.
- It also consumes the RAM's `r_data` (registered read, 1-cycle latency).

Parameters:
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 2, RAM word width.
- TARGET_ADDR, 12, address incremented on each `go`.

Ports:
- clk  input  1  system clock (12 MHz)
- rst  input  1  synchronous, active-high reset
- go  input  1  start request, single-cycle pulse, already debounced
- w_en  output  1  RAM write enable
- w_addr  output  ADDR_WIDTH  RAM write address
- w_data  output  DATA_WIDTH  RAM write data
- r_en  output  1  RAM read enable
- r_addr  output  ADDR_WIDTH  RAM read address
- r_data  input  DATA_WIDTH  RAM read data, valid the cycle after r_en
- out_valid  output  1  out_addr/out_data valid this cycle
- out_addr  output  ADDR_WIDTH  address of streamed word
- out_data  output  DATA_WIDTH  streamed word
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All outputs are registered.
- Reset state: state=IDLE; w_en=r_en=out_valid=busy=done=0; all address/data outputs=0; internal regs=0.
- FSM states: IDLE -> RD_REQ -> RD_WAIT -> WRITE -> SWEEP -> DRAIN -> DONE -> IDLE.
- IDLE: all strobes 0. `go`=1 sampled -> RD_REQ.
- RD_REQ (1 cycle): r_en=1, r_addr=TARGET_ADDR.
- RD_WAIT (1 cycle): r_en=0; capture r_data into rmw_reg at the end of the cycle.
- WRITE (1 cycle):
  - w_en=1, w_addr=TARGET_ADDR.
  - w_data=(rmw_reg+1) mod 2**DATA_WIDTH, so 3 wraps to 0.
  - Clear sweep counter cnt=0.
- SWEEP (DEPTH cycles):
  - r_en=1, r_addr=cnt; cnt increments each cycle.
  - On cnt==DEPTH-1 go to DRAIN; the counter does not wrap into a second pass.
- Stream pipeline: the read issued in cycle k of SWEEP produces out_valid=1, out_addr=k, out_data=r_data in the following cycle.
  - The first valid is in SWEEP cycle 1; the last (addr DEPTH-1) is in DRAIN.
- DRAIN (1 cycle): r_en=0; emits the last streamed word.
- DONE (1 cycle): done=1, out_valid=0; then IDLE.
- Strobe hygiene: w_en and r_en are never high in the same cycle. Address/data outputs return to 0 whenever their enable is 0.
- busy: high from RD_REQ through DONE inclusive, low in IDLE.
- Read-after-write: the WRITE-cycle write commits at its closing edge. The SWEEP read of TARGET_ADDR therefore returns the new value.
- Latency: `go` sampled at edge E0 gives the following edges:
  - RD_REQ at E1, WRITE at E3.
  - out_valid for addr k at E(5+k).
  - DRAIN (addr 15) at E20, done at E21, IDLE at E22.
- `go` while busy: ignored, not queued. `go` in the same cycle as the DONE state is ignored.
- `go` held high continuously: a new sequence starts on the first IDLE cycle. Consecutive sequences are separated by exactly one IDLE cycle.
- rst mid-operation:
  - Next edge forces IDLE with all strobes 0 and drops any in-flight stream or write; no partial done.
  - rst has priority over `go` in the same cycle.

Test Plan:
1. Reset/idle: assert rst 2 cycles, no go -> all outputs 0, busy=0 for 50 cycles; no w_en/r_en activity.
2. Single go, RAM addr12 preloaded 1 -> exactly one write at addr 12 with w_data=2.
   - Then 16 out_valid beats with out_addr 0..15 in order.
   - out_data matches the init file except addr12=2.
   - done 21 cycles after go.
3. Wrap-around: four go pulses spaced 40 cycles, addr12 init 1 -> streamed addr12 values 2,3,0,1. Other addresses unchanged.
4. go during busy: second go 5 cycles after the first -> only one write and one 16-beat stream; addr12 incremented once.
5. Reset mid-sweep: rst asserted at the 8th out_valid -> next cycle out_valid=r_en=busy=0, no done pulse.
   - A following go runs a complete sequence from addr 0.
6. go held high 60 cycles -> back-to-back sequences each with 1 IDLE gap. Every sequence has exactly 1 write and 16 beats.
   - Assert w_en and r_en are never high simultaneously throughout all tests.
